snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 Parameter MAX_LEN, 64, maximum body segments including head (4..1024).
REQ-002 Parameter COORD_W, 10, coordinate width in bits.
REQ-003 Parameter GRID_W, 640, playfield width in pixels.
REQ-004 Parameter GRID_H, 480, playfield height in pixels.
REQ-005 Parameter STEP, 10, pixels moved per step; GRID_W and GRID_H are multiples of STEP.
REQ-006 Parameter START_X / START_Y, 320 / 120, head position after init.
REQ-007 Parameter INIT_LEN, 3, length after init (2..MAX_LEN).
REQ-008 Port clock, in, 1: single clock; one clock; reset is synchronous and active-low.
REQ-009 Port reset, in, 1: synchronous active-low reset.
REQ-010 Port start, in, 1: level; begins or restarts a game.
REQ-011 Port step_en, in, 1: one-cycle move tick.
REQ-012 Port dir_req, in, 4: bit0 left, bit1 down, bit2 right, bit3 up.
REQ-013 Port grow, in, 1: one-cycle apple-eaten pulse.
REQ-014 Port rd_idx, in, clog2(MAX_LEN): segment read index; 0 is the head.
REQ-015 Port rd_x / rd_y, out, COORD_W each: segment coordinates.
REQ-016 Port rd_valid, out, 1: rd_idx < length.
REQ-017 Port head_x / head_y, out, COORD_W each: head coordinates.
REQ-018 Port length, out, clog2(MAX_LEN+1): current segment count.
REQ-019 Port state, out, 2: IDLE=0, RUN=1, DEAD=2.
REQ-020 Port game_over, out, 1: high while in DEAD.

Function
REQ-021 FSM transitions: IDLE->RUN when start=1; RUN->DEAD on self-collision; DEAD->IDLE when start=1, with body re-initialised in that same cycle.
REQ-022 Init state: seg[0]=(START_X,START_Y); seg[i]=(START_X-i*STEP,START_Y) for i<INIT_LEN; length=INIT_LEN; dir=right; grow_pend=0.
REQ-023 Direction priority when several dir_req bits are set: left > down > right > up.
REQ-024 A request opposite to the committed dir is ignored.
REQ-025 The accepted request is latched into pend_dir in any state except DEAD; the last accepted request before a step wins.
REQ-026 pend_dir is committed to dir only when the body moves.
REQ-027 In RUN with step_en=1, next_head = seg[0] + dir*STEP.
REQ-028 Horizontal wrap: x<0 -> GRID_W-STEP; x>=GRID_W -> 0.
REQ-029 Vertical wrap: y<0 -> GRID_H-STEP; y>=GRID_H -> 0.
REQ-030 Wrap arithmetic uses COORD_W+1-bit signed intermediates.
REQ-031 Self-collision occurs when next_head equals seg[i] for 1<=i<length-1, or for i=length-1 when the step grows.
REQ-032 On collision: body, length and dir unchanged; state becomes DEAD the next cycle.
REQ-033 On a normal step, all segments shift (seg[i]<=seg[i-1]) and seg[0]<=next_head in one cycle.
REQ-034 grow sets grow_pend; a grow arriving in the same cycle as step_en applies to that step.
REQ-035 A growing step increments length, saturating at MAX_LEN, and clears grow_pend.
REQ-036 Extra grow pulses before the next step do not accumulate.
REQ-037 step_en is ignored outside RUN.
REQ-038 grow is ignored in IDLE and DEAD.
REQ-039 rd_x/rd_y/rd_valid are registered, showing seg[rd_idx] one cycle after rd_idx is presented.
REQ-040 When rd_valid=0, rd_x/rd_y read 0.
REQ-041 head_x, head_y, length, state and game_over are registered.

Reset
REQ-042 reset=0 at a clock edge forces init state (REQ-022), state=IDLE, game_over=0, rd_*=0, overriding any in-progress step, grow or start.

Structure
REQ-043 A shared package holds the state enum, the direction encoding and a dir-to-delta function.
REQ-044 Sub-module snake_wrap_step computes next_head (delta plus wrap) combinationally.

Verification
REQ-045 Reset, start, 3 steps with no dir_req -> head (350,120), length 3, tail (330,120).
REQ-046 Head at (630,200), dir right, step -> head (0,200); head at (x,0), dir up, step -> head (x,470).
REQ-047 dir=right, dir_req=left then step -> head x+10; dir_req=up,left together then step -> left accepted, x-10.
REQ-048 grow and step_en in the same cycle, length 3 -> length 4 and tail unchanged; grow at MAX_LEN -> length stays MAX_LEN.
REQ-049 Length 5 driven into a square loop -> state DEAD, game_over=1, body frozen; start -> IDLE with init body.
REQ-050 Sweep rd_idx 0..MAX_LEN-1 -> 1-cycle latency, rd_valid high only below length; reset=0 mid-step -> init values next cycle.

Source files
------------

// File: rtl/snake_body_engine_pkg.sv
// Shared types for the snake body engine: game states, move directions
// and the helpers that turn a direction into a unit step.
package snake_body_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Opposite directions differ only in bit 1.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input dir_t d);
        delta_t r;
        r.dx = 2'sd0;
        r.dy = 2'sd0;
        case (d)
            DIR_LEFT:  r.dx = -2'sd1;
            DIR_RIGHT: r.dx = 2'sd1;
            DIR_UP:    r.dy = -2'sd1;
            DIR_DOWN:  r.dy = 2'sd1;
            default:   r.dx = 2'sd0;
        endcase
        return r;
    endfunction

    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Left wins over down, down over right, right over up.
    function automatic dir_t dir_pick(input logic [3:0] req);
        dir_t r;
        if (req[0])      r = DIR_LEFT;
        else if (req[1]) r = DIR_DOWN;
        else if (req[2]) r = DIR_RIGHT;
        else             r = DIR_UP;
        return r;
    endfunction

endpackage

// File: rtl/snake_wrap_step.sv
// Combinational next-head calculation: one STEP in the given direction,
// wrapping toroidally at the playfield edges.
module snake_wrap_step
    import snake_body_engine_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int GRID_W  = 640,
    parameter int GRID_H  = 480,
    parameter int STEP    = 10
) (
    input  logic [COORD_W-1:0] i_cur_x,
    input  logic [COORD_W-1:0] i_cur_y,
    input  dir_t               i_dir,
    output logic [COORD_W-1:0] o_next_x,
    output logic [COORD_W-1:0] o_next_y
);

    localparam int SW = COORD_W + 1;
    localparam logic signed [COORD_W:0] STEP_S   = SW'(STEP);
    localparam logic signed [COORD_W:0] GRID_W_S = SW'(GRID_W);
    localparam logic signed [COORD_W:0] GRID_H_S = SW'(GRID_H);
    localparam logic [COORD_W-1:0]      WRAP_X   = COORD_W'(GRID_W - STEP);
    localparam logic [COORD_W-1:0]      WRAP_Y   = COORD_W'(GRID_H - STEP);

    delta_t                    w_delta;
    logic signed [COORD_W:0]   w_off_x;
    logic signed [COORD_W:0]   w_off_y;
    logic signed [COORD_W:0]   w_sum_x;
    logic signed [COORD_W:0]   w_sum_y;

    always_comb begin
        w_delta = dir_delta(i_dir);
        w_off_x = '0;
        w_off_y = '0;
        if (w_delta.dx == 2'b01)      w_off_x = STEP_S;
        else if (w_delta.dx == 2'b11) w_off_x = -STEP_S;
        if (w_delta.dy == 2'b01)      w_off_y = STEP_S;
        else if (w_delta.dy == 2'b11) w_off_y = -STEP_S;

        w_sum_x = $signed({1'b0, i_cur_x}) + w_off_x;
        w_sum_y = $signed({1'b0, i_cur_y}) + w_off_y;

        o_next_x = w_sum_x[COORD_W-1:0];
        if (w_sum_x < 0)              o_next_x = WRAP_X;
        else if (w_sum_x >= GRID_W_S) o_next_x = '0;

        o_next_y = w_sum_y[COORD_W-1:0];
        if (w_sum_y < 0)              o_next_y = WRAP_Y;
        else if (w_sum_y >= GRID_H_S) o_next_y = '0;
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and game FSM: shifts the segment list on each move tick,
// handles growth, direction filtering, self-collision and a registered read port.
module snake_body_engine
    import snake_body_engine_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int COORD_W  = 10,
    parameter int GRID_W   = 640,
    parameter int GRID_H   = 480,
    parameter int STEP     = 10,
    parameter int START_X  = 320,
    parameter int START_Y  = 120,
    parameter int INIT_LEN = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         step_en,
    input  logic [3:0]                   dir_req,
    input  logic                         grow,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
    output logic [COORD_W-1:0]           rd_x,
    output logic [COORD_W-1:0]           rd_y,
    output logic                         rd_valid,
    output logic [COORD_W-1:0]           head_x,
    output logic [COORD_W-1:0]           head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [1:0]                   state,
    output logic                         game_over
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] INIT_LEN_L = LEN_W'(INIT_LEN);

    function automatic logic [COORD_W-1:0] init_x(input int i);
        logic [COORD_W-1:0] r;
        r = '0;
        if (i < INIT_LEN) r = COORD_W'(START_X - i * STEP);
        return r;
    endfunction

    logic [COORD_W-1:0] r_seg_x [MAX_LEN];
    logic [COORD_W-1:0] r_seg_y [MAX_LEN];
    logic [LEN_W-1:0]   r_length;
    dir_t               r_dir;
    dir_t               r_pend_dir;
    logic               r_grow_pend;
    state_t             r_state;
    logic               r_game_over;
    logic [COORD_W-1:0] r_rd_x;
    logic [COORD_W-1:0] r_rd_y;
    logic               r_rd_valid;

    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;
    dir_t               w_req_dir;
    logic               w_accept;
    logic               w_growing;
    logic               w_collide;
    logic               w_rd_hit;
    state_t             w_state_nxt;
    logic               w_do_move;
    logic               w_do_init;
    logic               w_grow_set;
    logic               w_latch_ok;

    // The head always advances in the pending direction; it becomes committed on the move.
    snake_wrap_step #(
        .COORD_W (COORD_W),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .STEP    (STEP)
    ) u_wrap_step (
        .i_cur_x  (r_seg_x[0]),
        .i_cur_y  (r_seg_y[0]),
        .i_dir    (r_pend_dir),
        .o_next_x (w_next_x),
        .o_next_y (w_next_y)
    );

    always_comb begin
        w_req_dir = dir_pick(dir_req);
        w_accept  = w_latch_ok && (|dir_req) && (w_req_dir != dir_opposite(r_dir));
        w_growing = (r_grow_pend || grow) && (r_length < MAX_LEN_L);
    end

    // The tail cell is only an obstacle when it stays put, i.e. on a growing step.
    always_comb begin
        w_collide = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((w_next_x == r_seg_x[i]) && (w_next_y == r_seg_y[i])) begin
                if ((i < int'(r_length) - 1) || ((i == int'(r_length) - 1) && w_growing))
                    w_collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_game_over <= (w_state_nxt == ST_DEAD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (step_en && w_collide) w_state_nxt = ST_DEAD;
            ST_DEAD: if (start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_do_move  = (r_state == ST_RUN) && step_en && !w_collide;
        w_do_init  = (r_state == ST_DEAD) && start;
        w_grow_set = (r_state == ST_RUN) && grow;
        w_latch_ok = (r_state != ST_DEAD);
    end

    always_ff @(posedge clock) begin
        if (!reset || w_do_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_x(i);
                r_seg_y[i] <= (i < INIT_LEN) ? COORD_W'(START_Y) : '0;
            end
            r_length    <= INIT_LEN_L;
            r_dir       <= DIR_RIGHT;
            r_pend_dir  <= DIR_RIGHT;
            r_grow_pend <= 1'b0;
        end else begin
            if (w_do_move) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0]  <= w_next_x;
                r_seg_y[0]  <= w_next_y;
                r_dir       <= r_pend_dir;
                r_grow_pend <= 1'b0;
                if (w_growing) r_length <= r_length + 1'b1;
            end else if (w_grow_set) begin
                r_grow_pend <= 1'b1;
            end
            if (w_accept) r_pend_dir <= w_req_dir;
        end
    end

    assign w_rd_hit = (LEN_W'(rd_idx) < r_length);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_hit;
            r_rd_x     <= w_rd_hit ? r_seg_x[rd_idx] : '0;
            r_rd_y     <= w_rd_hit ? r_seg_y[rd_idx] : '0;
        end
    end

    assign rd_x      = r_rd_x;
    assign rd_y      = r_rd_y;
    assign rd_valid  = r_rd_valid;
    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign length    = r_length;
    assign state     = r_state;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a table of single-cycle vectors with
// hand-computed results, plus sequences for wrap, saturation, read sweep and reset.
module tb_snake_body_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       step_en = 1'b0;
    logic       grow = 1'b0;
    logic [3:0] dir_req = 4'd0;
    logic [5:0] rd_idx = 6'd0;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_valid;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [6:0] length;
    logic [1:0] state;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    snake_body_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .step_en   (step_en),
        .dir_req   (dir_req),
        .grow      (grow),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_valid  (rd_valid),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .state     (state),
        .game_over (game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       st;
        logic       stp;
        logic       gr;
        logic [3:0] dr;
        int         hx;
        int         hy;
        int         len;
        int         state;
        logic       rc;
        int         ri;
        int         rv;
        int         rx;
        int         ry;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic st, input logic stp, input logic gr, input logic [3:0] dr,
                                input int hx, input int hy, input int len, input int stt,
                                input logic rc, input int ri, input int rv, input int rx, input int ry);
        vec_t v;
        v.st = st; v.stp = stp; v.gr = gr; v.dr = dr;
        v.hx = hx; v.hy = hy; v.len = len; v.state = stt;
        v.rc = rc; v.ri = ri; v.rv = rv; v.rx = rx; v.ry = ry;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic se, input logic g, input logic [3:0] d);
        start = s; step_en = se; grow = g; dir_req = d;
        tick();
        start = 1'b0; step_en = 1'b0; grow = 1'b0; dir_req = 4'd0;
    endtask

    task automatic steps(input int n, input logic g);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, g, 4'd0);
    endtask

    task automatic check_head(input string name, input int hx, input int hy, input int len, input int st);
        check({name, " head_x"}, head_x, hx);
        check({name, " head_y"}, head_y, hy);
        check({name, " length"}, length, len);
        check({name, " state"}, state, st);
        check({name, " game_over"}, game_over, (st == 2) ? 1 : 0);
    endtask

    task automatic check_rd(input string name, input int idx, input int v, input int x, input int y);
        rd_idx = 6'(idx);
        tick();
        check({name, " rd_valid"}, rd_valid, v);
        check({name, " rd_x"}, rd_x, x);
        check({name, " rd_y"}, rd_y, y);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        //               st stp gr dr   hx   hy  len st  rc ri rv  rx   ry
        vecs[0]  = mk(1, 0, 0, 4'd0, 320, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[1]  = mk(0, 1, 0, 4'd0, 330, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[2]  = mk(0, 1, 0, 4'd0, 340, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[3]  = mk(0, 1, 0, 4'd0, 350, 120, 3, 1, 1, 2, 1, 330, 120);
        vecs[4]  = mk(0, 0, 0, 4'd1, 350, 120, 3, 1, 1, 3, 0, 0,   0);
        vecs[5]  = mk(0, 1, 0, 4'd0, 360, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[6]  = mk(0, 0, 0, 4'd8, 360, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[7]  = mk(0, 1, 0, 4'd0, 360, 110, 3, 1, 0, 0, 0, 0,   0);
        vecs[8]  = mk(0, 0, 0, 4'd9, 360, 110, 3, 1, 0, 0, 0, 0,   0);
        vecs[9]  = mk(0, 1, 0, 4'd0, 350, 110, 3, 1, 0, 0, 0, 0,   0);
        vecs[10] = mk(0, 1, 1, 4'd0, 340, 110, 4, 1, 1, 3, 1, 360, 120);
        vecs[11] = mk(0, 0, 1, 4'd0, 340, 110, 4, 1, 0, 0, 0, 0,   0);
        vecs[12] = mk(0, 0, 1, 4'd0, 340, 110, 4, 1, 0, 0, 0, 0,   0);
        vecs[13] = mk(0, 1, 0, 4'd0, 330, 110, 5, 1, 0, 0, 0, 0,   0);
        vecs[14] = mk(0, 1, 0, 4'd0, 320, 110, 5, 1, 1, 4, 1, 360, 110);
        vecs[15] = mk(0, 0, 0, 4'd2, 320, 110, 5, 1, 0, 0, 0, 0,   0);
        vecs[16] = mk(0, 1, 0, 4'd0, 320, 120, 5, 1, 0, 0, 0, 0,   0);
        vecs[17] = mk(0, 0, 0, 4'd4, 320, 120, 5, 1, 0, 0, 0, 0,   0);
        vecs[18] = mk(0, 1, 0, 4'd0, 330, 120, 5, 1, 0, 0, 0, 0,   0);
        vecs[19] = mk(0, 0, 0, 4'd8, 330, 120, 5, 1, 0, 0, 0, 0,   0);
        vecs[20] = mk(0, 1, 0, 4'd0, 330, 120, 5, 2, 0, 0, 0, 0,   0);
        vecs[21] = mk(0, 1, 0, 4'd0, 330, 120, 5, 2, 1, 4, 1, 340, 110);
        vecs[22] = mk(0, 1, 1, 4'd0, 330, 120, 5, 2, 0, 0, 0, 0,   0);
        vecs[23] = mk(0, 0, 0, 4'd1, 330, 120, 5, 2, 0, 0, 0, 0,   0);
        vecs[24] = mk(1, 0, 0, 4'd0, 320, 120, 3, 0, 1, 2, 1, 300, 120);
        vecs[25] = mk(0, 1, 0, 4'd0, 320, 120, 3, 0, 0, 0, 0, 0,   0);
        vecs[26] = mk(0, 0, 1, 4'd0, 320, 120, 3, 0, 0, 0, 0, 0,   0);
        vecs[27] = mk(1, 0, 0, 4'd0, 320, 120, 3, 1, 0, 0, 0, 0,   0);
        vecs[28] = mk(0, 1, 0, 4'd0, 330, 120, 3, 1, 1, 2, 1, 310, 120);

        // Reset state, with the read port aimed at the head while reset is held.
        reset = 1'b0;
        rd_idx = 6'd0;
        tick();
        tick();
        check_head("reset", 320, 120, 3, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_x", rd_x, 0);
        check("reset rd_y", rd_y, 0);
        reset = 1'b1;
        tick();
        check("post-reset state", state, 0);

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].st, vecs[i].stp, vecs[i].gr, vecs[i].dr);
            check_head($sformatf("v%0d", i), vecs[i].hx, vecs[i].hy, vecs[i].len, vecs[i].state);
            if (vecs[i].rc)
                check_rd($sformatf("v%0d", i), vecs[i].ri, vecs[i].rv, vecs[i].rx, vecs[i].ry);
        end

        // Read sweep with body (330,120),(320,120),(310,120); the output lags rd_idx by one cycle.
        rd_idx = 6'd0;
        for (int i = 0; i < 64; i++) begin
            tick();
            rd_idx = 6'((i + 1) % 64);
            #1;
            check($sformatf("sweep%0d rd_valid", i), rd_valid, (i < 3) ? 1 : 0);
            check($sformatf("sweep%0d rd_x", i), rd_x, (i < 3) ? 330 - 10 * i : 0);
            check($sformatf("sweep%0d rd_y", i), rd_y, (i < 3) ? 120 : 0);
        end

        // Edge wrap: right edge to x=0, top edge to y=470.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 4'd2);
        steps(8, 1'b0);
        check_head("wrap down", 320, 200, 3, 1);
        drive(1'b0, 1'b0, 1'b0, 4'd4);
        steps(31, 1'b0);
        check_head("wrap at edge", 630, 200, 3, 1);
        steps(1, 1'b0);
        check_head("wrap right", 0, 200, 3, 1);
        drive(1'b0, 1'b0, 1'b0, 4'd8);
        steps(20, 1'b0);
        check_head("wrap at top", 0, 0, 3, 1);
        steps(1, 1'b0);
        check_head("wrap up", 0, 470, 3, 1);

        // Grow on every step along an L-shaped path until the length saturates.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        steps(30, 1'b1);
        check_head("grow row", 620, 120, 33, 1);
        drive(1'b0, 1'b0, 1'b0, 4'd2);
        steps(45, 1'b1);
        check_head("grow col", 620, 90, 64, 1);
        steps(2, 1'b1);
        check_head("grow sat", 620, 110, 64, 1);
        check_rd("grow tail", 63, 1, 460, 120);

        // Reset in the same cycle as step, grow, start and a direction request.
        rd_idx = 6'd5;
        start = 1'b1; step_en = 1'b1; grow = 1'b1; dir_req = 4'd1; reset = 1'b0;
        tick();
        start = 1'b0; step_en = 1'b0; grow = 1'b0; dir_req = 4'd0; reset = 1'b1;
        check_head("mid reset", 320, 120, 3, 0);
        check("mid reset rd_valid", rd_valid, 0);
        check("mid reset rd_x", rd_x, 0);
        check_rd("mid reset seg2", 2, 1, 300, 120);
        check_rd("mid reset seg5", 5, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
